// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared processor widths and the writeback result record
package wb_arbiter_pkg;
  localparam int NUM_REQ = 3;
  localparam int XLEN = 32;
  localparam int PREG_W = 7;
  localparam int ROB_W = 5;
  localparam int SRC_W = 2;
  typedef struct packed {
    logic [PREG_W-1:0] prd;
    logic [XLEN-1:0]   data;
    logic [ROB_W-1:0]  rob_tag;
  } wb_result_t;
endpackage

// File: rtl/wb_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick over req starting at ptr
//   req   : request vector
//   ptr   : highest-priority index this cycle
//   grant : one-hot grant, idx : granted index, any : some grant issued
module rr_arbiter #(
  parameter int N = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] pos [N];
  for (genvar k = 0; k < N; k++) begin : g_pos
    assign pos[k] = IW'((int'(ptr) + k) % N);
  end
  // scan from farthest to nearest so the nearest request to ptr wins
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[pos[k]]) begin
        grant = '0;
        grant[pos[k]] = 1'b1;
        idx = pos[k];
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges per-FU results into one registered common data bus
//   clk, reset (async, active-low), flush kills all in-flight results
//   req_valid/req_ready/req_prd/req_data/req_rob_tag : per-requester result inputs
//   cdb_valid/cdb_we/cdb_prd/cdb_data/cdb_rob_tag/cdb_src : broadcast result
module wb_arbiter import wb_arbiter_pkg::*; #(
  parameter int NUM_REQ = wb_arbiter_pkg::NUM_REQ,
  parameter int XLEN = wb_arbiter_pkg::XLEN,
  parameter int PREG_W = wb_arbiter_pkg::PREG_W,
  parameter int ROB_W = wb_arbiter_pkg::ROB_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*PREG_W-1:0] req_prd,
  input  logic [NUM_REQ*XLEN-1:0]   req_data,
  input  logic [NUM_REQ*ROB_W-1:0]  req_rob_tag,
  output logic                      cdb_valid,
  output logic                      cdb_we,
  output logic [PREG_W-1:0]         cdb_prd,
  output logic [XLEN-1:0]           cdb_data,
  output logic [ROB_W-1:0]          cdb_rob_tag,
  output logic [SRC_W-1:0]          cdb_src
);
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] hold_v, grant, accept, arb_req;
  logic [PREG_W-1:0]  hold_prd  [NUM_REQ];
  logic [XLEN-1:0]    hold_data [NUM_REQ];
  logic [ROB_W-1:0]   hold_tag  [NUM_REQ];
  logic [IW-1:0]      rr_ptr, gidx;
  logic               any_grant;
  // flush masks arbitration, so no grant, no pointer move and no accept that cycle
  assign arb_req = hold_v & {NUM_REQ{~flush}};
  assign req_ready = (~hold_v | grant) & {NUM_REQ{~flush}};
  assign accept = req_valid & req_ready;
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req(arb_req),
    .ptr(rr_ptr),
    .grant(grant),
    .idx(gidx),
    .any(any_grant)
  );
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        hold_prd[i] <= req_prd[i*PREG_W +: PREG_W];
        hold_data[i] <= req_data[i*XLEN +: XLEN];
        hold_tag[i] <= req_rob_tag[i*ROB_W +: ROB_W];
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_v <= '0;
      rr_ptr <= '0;
      cdb_valid <= 1'b0;
      cdb_we <= 1'b0;
      cdb_prd <= '0;
      cdb_data <= '0;
      cdb_rob_tag <= '0;
      cdb_src <= '0;
    end else begin
      // a granted hold empties unless a new result lands the same edge
      hold_v <= flush ? '0 : accept | (hold_v & ~grant);
      cdb_valid <= any_grant;
      cdb_we <= any_grant && hold_prd[gidx] != '0;
      if (any_grant) begin
        rr_ptr <= (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
        cdb_prd <= hold_prd[gidx];
        cdb_data <= hold_data[gidx];
        cdb_rob_tag <= hold_tag[gidx];
        cdb_src <= SRC_W'(gidx);
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and scoreboarded random checks of wb_arbiter
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;
  localparam int N = 3;
  logic clk = 1'b0, reset = 1'b0, flush = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*PREG_W-1:0] req_prd = '0;
  logic [N*XLEN-1:0] req_data = '0;
  logic [N*ROB_W-1:0] req_rob_tag = '0;
  logic cdb_valid, cdb_we;
  logic [PREG_W-1:0] cdb_prd;
  logic [XLEN-1:0] cdb_data;
  logic [ROB_W-1:0] cdb_rob_tag;
  logic [SRC_W-1:0] cdb_src;
  int checks = 0, failures = 0, cyc = 0;
  wb_result_t sq [N][$];
  int sa [N][$];
  wb_arbiter dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_prd(req_prd), .req_data(req_data), .req_rob_tag(req_rob_tag),
    .cdb_valid(cdb_valid), .cdb_we(cdb_we), .cdb_prd(cdb_prd),
    .cdb_data(cdb_data), .cdb_rob_tag(cdb_rob_tag), .cdb_src(cdb_src)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic set_port(input int i, input logic [PREG_W-1:0] p, input logic [XLEN-1:0] d, input logic [ROB_W-1:0] t);
    req_prd[i*PREG_W +: PREG_W] = p;
    req_data[i*XLEN +: XLEN] = d;
    req_rob_tag[i*ROB_W +: ROB_W] = t;
  endtask
  initial begin
    tick;
    chk("rst_cdb_valid", cdb_valid, 0);
    chk("rst_cdb_we", cdb_we, 0);
    chk("rst_cdb_data", cdb_data, 0);
    chk("rst_ready", req_ready, 3'b111);
    tick;
    reset = 1'b1;
    set_port(0, 7'd5, 32'hDEADBEEF, 5'd3);
    req_valid = 3'b001;
    tick;
    req_valid = '0;
    chk("alu_latency", cdb_valid, 0);
    tick;
    chk("alu_valid", cdb_valid, 1);
    chk("alu_we", cdb_we, 1);
    chk("alu_src", cdb_src, 0);
    chk("alu_prd", cdb_prd, 5);
    chk("alu_data", cdb_data, 32'hDEADBEEF);
    chk("alu_tag", cdb_rob_tag, 3);
    tick;
    chk("idle_valid", cdb_valid, 0);
    chk("idle_data_hold", cdb_data, 32'hDEADBEEF);
    set_port(1, 7'd0, 32'h1234, 5'd7);
    req_valid = 3'b010;
    tick;
    req_valid = '0;
    tick;
    chk("br_valid", cdb_valid, 1);
    chk("br_we", cdb_we, 0);
    chk("br_tag", cdb_rob_tag, 7);
    chk("br_src", cdb_src, 1);
    tick;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    for (int i = 0; i < N; i++) set_port(i, 7'(i + 1), 32'hA0 + 32'(i), 5'(i + 10));
    req_valid = 3'b111;
    #1;
    chk("rr_ready_first", req_ready, 3'b111);
    tick;
    for (int n = 0; n < 6; n++) begin
      chk("rr_ready", req_ready, 3'b001 << (n % 3));
      tick;
      chk("rr_valid", cdb_valid, 1);
      chk("rr_src", cdb_src, n % 3);
      chk("rr_data", cdb_data, 32'hA0 + n % 3);
    end
    req_valid = '0;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    req_valid = 3'b101;
    tick;
    flush = 1'b1;
    req_valid = 3'b010;
    #1;
    chk("flush_ready", req_ready, 0);
    tick;
    flush = 1'b0;
    req_valid = '0;
    #1;
    chk("flush_cdb_valid", cdb_valid, 0);
    chk("flush_ready_after", req_ready, 3'b111);
    chk("flush_rr_ptr", dut.rr_ptr, 0);
    tick;
    chk("flush_no_branch", cdb_valid, 0);
    req_valid = 3'b111;
    tick;
    tick;
    req_valid = '0;
    chk("pre_reset_valid", cdb_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_valid", cdb_valid, 0);
    chk("async_we", cdb_we, 0);
    chk("async_prd", cdb_prd, 0);
    chk("async_data", cdb_data, 0);
    chk("async_tag", cdb_rob_tag, 0);
    chk("async_src", cdb_src, 0);
    chk("async_ready", req_ready, 3'b111);
    #1;
    reset = 1'b1;
    req_valid = 3'b111;
    tick;
    req_valid = '0;
    for (int n = 0; n < 3; n++) begin
      tick;
      chk("post_rst_valid", cdb_valid, 1);
      chk("post_rst_src", cdb_src, n);
    end
    tick;
    chk("post_rst_idle", cdb_valid, 0);
    for (int n = 0; n < 10000; n++) begin
      wb_result_t ent [N];
      logic [N-1:0] acc;
      logic f;
      int s;
      f = (n < 9990) && ($urandom_range(0, 31) == 0);
      for (int i = 0; i < N; i++) begin
        ent[i].prd = ($urandom_range(0, 3) == 0) ? '0 : PREG_W'($urandom);
        ent[i].data = 32'(i) * 32'h0100_0000 + 32'(n);
        ent[i].rob_tag = ROB_W'($urandom);
        set_port(i, ent[i].prd, ent[i].data, ent[i].rob_tag);
      end
      flush = f;
      req_valid = (n < 9990) ? N'($urandom) : '0;
      #1;
      acc = req_valid & req_ready;
      tick;
      if (f) begin
        chk("rnd_flush_valid", cdb_valid, 0);
        for (int i = 0; i < N; i++) begin
          sq[i].delete();
          sa[i].delete();
        end
      end else begin
        if (cdb_valid) begin
          s = int'(cdb_src);
          chk("sb_hit", (s < N) ? (sq[s].size() != 0) : 1'b0, 1);
          if (s < N && sq[s].size() != 0) begin
            chk("sb_prd", cdb_prd, sq[s][0].prd);
            chk("sb_data", cdb_data, sq[s][0].data);
            chk("sb_tag", cdb_rob_tag, sq[s][0].rob_tag);
            chk("sb_we", cdb_we, sq[s][0].prd != '0);
            chk("sb_wait", (cyc - sa[s][0]) <= 3, 1);
            void'(sq[s].pop_front());
            void'(sa[s].pop_front());
          end
        end else begin
          chk("rnd_idle_we", cdb_we, 0);
        end
        for (int i = 0; i < N; i++) begin
          if (acc[i]) begin
            sq[i].push_back(ent[i]);
            sa[i].push_back(cyc);
          end
        end
      end
    end
    flush = 1'b0;
    chk("sb_drained", sq[0].size() + sq[1].size() + sq[2].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
